// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, frame-granular sharing of one UART transmitter
//            among N_REQ requesters, with a per-byte completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int FRAME_BYTES  = 2,
    parameter int TIMEOUT_CLKS = 65535
) (
    input  logic                           i_Clock,
    input  logic                           i_Rst_n,
    input  logic [N_REQ-1:0]               i_Req,
    input  logic [N_REQ*FRAME_BYTES*8-1:0] i_Frame,
    output logic [N_REQ-1:0]               o_Grant,
    output logic [N_REQ-1:0]               o_Done,
    output logic [N_REQ-1:0]               o_Err,
    output logic                           o_Tx_DV,
    output logic [7:0]                     o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done,
    output logic                           o_Busy
);

    localparam int c_FRAME_W = FRAME_BYTES * 8;
    localparam int c_IDX_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int c_REQ_W   = $clog2(N_REQ);
    localparam int c_CNT_W   = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t               r_state, w_state_next;
    logic [c_FRAME_W-1:0] r_buf, w_buf_next;
    logic [c_IDX_W-1:0]   r_idx, w_idx_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
    logic [c_REQ_W-1:0]   r_owner, w_owner_next;
    logic [c_REQ_W-1:0]   r_last, w_last_next;
    logic [N_REQ-1:0]     w_grant_next, w_done_next, w_err_next;
    logic                 w_dv_next, w_busy_next;
    logic [7:0]           w_byte_next;

    logic [2*N_REQ-1:0]   w_req2;
    logic                 w_found;
    logic [c_REQ_W-1:0]   w_pick;
    logic [c_FRAME_W-1:0] w_sel_frame;
    logic [N_REQ-1:0]     w_pick_onehot, w_owner_onehot;

    assign w_req2         = {i_Req, i_Req};
    assign w_pick_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    assign w_owner_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_cnt_inc      = r_cnt + c_CNT_W'(1);

    // Scan the doubled request vector from last_granted+1 for N_REQ positions,
    // which gives the wrapping round-robin search without a modulo on r_last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (!w_found && w_req2[i] && (i > int'(r_last)) && (i <= int'(r_last) + N_REQ)) begin
                w_found = 1'b1;
                w_pick  = c_REQ_W'(i % N_REQ);
            end
        end
    end

    always_comb begin
        w_sel_frame = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick == c_REQ_W'(k)) begin
                w_sel_frame = i_Frame[k*c_FRAME_W +: c_FRAME_W];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_owner_next = r_owner;
        w_last_next  = r_last;
        w_grant_next = '0;
        w_done_next  = '0;
        w_err_next   = '0;
        w_dv_next    = 1'b0;
        w_byte_next  = o_Tx_Byte;
        w_busy_next  = o_Busy;

        case (r_state)
            IDLE: begin
                // Busy stays high only through the Err cycle that lands here.
                w_busy_next = 1'b0;
                if (w_found && !i_Tx_Active) begin
                    w_owner_next = w_pick;
                    w_grant_next = w_pick_onehot;
                    w_dv_next    = 1'b1;
                    w_byte_next  = w_sel_frame[7:0];
                    w_buf_next   = w_sel_frame >> 8;
                    w_idx_next   = '0;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                w_cnt_next = w_cnt_inc;
                if (i_Tx_Done) begin
                    if (r_idx == c_IDX_W'(FRAME_BYTES-1)) begin
                        w_done_next  = w_owner_onehot;
                        w_last_next  = r_owner;
                        w_state_next = FINISH;
                    end else begin
                        w_idx_next   = r_idx + c_IDX_W'(1);
                        w_state_next = GAP;
                    end
                end else if (w_cnt_inc == c_CNT_W'(TIMEOUT_CLKS)) begin
                    w_err_next   = w_owner_onehot;
                    w_last_next  = r_owner;
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end
            end
            GAP: begin
                if (!i_Tx_Active) begin
                    w_dv_next    = 1'b1;
                    w_byte_next  = r_buf[7:0];
                    w_buf_next   = r_buf >> 8;
                    w_cnt_next   = '0;
                    w_state_next = WAIT_DONE;
                end
            end
            FINISH: begin
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_owner   <= '0;
            r_last    <= c_REQ_W'(N_REQ-1);
            o_Grant   <= '0;
            o_Done    <= '0;
            o_Err     <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
            o_Busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_buf     <= w_buf_next;
            r_idx     <= w_idx_next;
            r_cnt     <= w_cnt_next;
            r_owner   <= w_owner_next;
            r_last    <= w_last_next;
            o_Grant   <= w_grant_next;
            o_Done    <= w_done_next;
            o_Err     <= w_err_next;
            o_Tx_DV   <= w_dv_next;
            o_Tx_Byte <= w_byte_next;
            o_Busy    <= w_busy_next;
        end
    end

endmodule

`default_nettype wire
